// File: rtl/pll_reconf_pkg.sv
// rtl/pll_reconf_pkg.sv - shared types and constants for the PLL reconfiguration sequencer
package pll_reconf_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RSTP  = 3'd2,
    ST_FETCH = 3'd3,
    ST_RD    = 3'd4,
    ST_WR    = 3'd5,
    ST_REL   = 3'd6,
    ST_WLOCK = 3'd7
  } state_e;

  // Table entry layout: {drp_addr[4:0], keep_mask[15:0], set_value[15:0]}
  localparam int TBL_W     = 37;
  localparam int ADDR_LSB  = 32;
  localparam int MASK_LSB  = 16;
  localparam int VAL_LSB   = 0;

  // Consecutive synchronised-high cycles required before lock is trusted
  localparam int LOCK_QUAL = 8;

  // Read-modify-write merge: keep the masked bits of the current value, OR in the new ones
  function automatic logic [15:0] rmw(input logic [15:0] rd_val,
                                      input logic [15:0] keep,
                                      input logic [15:0] set_val);
    return (rd_val & keep) | set_val;
  endfunction

endpackage

// File: rtl/lock_qual.sv
// rtl/lock_qual.sv - PLL lock synchroniser and consecutive-cycle qualifier
module lock_qual
  import pll_reconf_pkg::*;
(
  input  logic clk,
  input  logic rstx,
  input  logic locked,
  input  logic qual_en,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_QUAL + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d;

  // Count synchronised-high cycles while qualification is enabled; any low sample restarts it
  always_comb begin
    sync1_d = locked;
    sync2_d = sync1_q;
    cnt_d   = '0;
    ok_d    = 1'b0;
    if (qual_en && sync2_q) begin
      cnt_d = (cnt_q == CW'(LOCK_QUAL)) ? cnt_q : cnt_q + CW'(1);
      ok_d  = (cnt_q >= CW'(LOCK_QUAL - 1));
    end
  end

  // Synchroniser and qualifier registers
  always_ff @(posedge clk) begin
    if (!rstx) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
    end
  end

  assign lock_ok = ok_q;

endmodule

// File: rtl/pll_reconf_seq.sv
// rtl/pll_reconf_seq.sv - table-driven PLL DRP reconfiguration sequencer with lock wait and retry
module pll_reconf_seq
  import pll_reconf_pkg::*;
#(
  parameter int NCFG     = 4,
  parameter int NREG     = 23,
  parameter int INIT_CFG = 0,
  parameter int RST_CYC  = 16,
  parameter int DRDY_TO  = 64,
  parameter int LOCK_TO  = 65536,
  parameter int RETRY    = 2,
  localparam int AW = (NCFG > 1) ? $clog2(NCFG) : 1,
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic [AW-1:0]     CFG_SEL,
  input  logic              CFG_REQ,
  output logic              CFG_BUSY,
  output logic              CFG_DONE,
  output logic              CFG_ERR,
  output logic [AW+IW-1:0]  TBL_ADDR,
  input  logic [TBL_W-1:0]  TBL_DATA,
  output logic [4:0]        DADDR,
  output logic [15:0]       DI,
  input  logic [15:0]       DO,
  output logic              DEN,
  output logic              DWE,
  input  logic              DRDY,
  input  logic              LOCKED,
  output logic              RST_PLL,
  output logic              LOCK_OK
);

  // One shared timer serves the reset hold, DRDY watchdog and lock watchdog
  localparam int TMAX = (LOCK_TO > DRDY_TO) ? ((LOCK_TO > RST_CYC) ? LOCK_TO : RST_CYC)
                                            : ((DRDY_TO > RST_CYC) ? DRDY_TO : RST_CYC);
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = (RETRY > 0) ? $clog2(RETRY + 1) : 1;

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TO - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TO - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NREG - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY);

  state_e            state_q, state_d;
  logic [AW-1:0]     cfg_q, cfg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tmr_q, tmr_d, tmr_inc;
  logic [RW-1:0]     retry_q, retry_d;
  logic              ph_q, ph_d;
  logic [AW+IW-1:0]  tbl_addr_q, tbl_addr_d;
  logic [4:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic              rst_pll_q, rst_pll_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              qual_en;
  logic              lock_ok;

  assign qual_en = (state_q == ST_WLOCK) || (state_q == ST_IDLE);

  lock_qual u_lock_qual (
    .clk     (CLK),
    .rstx    (RSTX),
    .locked  (LOCKED),
    .qual_en (qual_en),
    .lock_ok (lock_ok)
  );

  // Sequencer next-state: DEN/DWE/DONE default low so each is a single-cycle pulse
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    retry_d    = retry_q;
    ph_d       = ph_q;
    tbl_addr_d = tbl_addr_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    rst_pll_d  = rst_pll_q;
    done_d     = 1'b0;
    err_d      = err_q;
    tmr_inc    = (tmr_q == {TW{1'b1}}) ? tmr_q : tmr_q + TW'(1);

    case (state_q)
      ST_BOOT: begin
        state_d   = ST_RSTP;
        rst_pll_d = 1'b1;
        idx_d     = '0;
        tmr_d     = '0;
      end
      ST_IDLE: begin
        if (CFG_REQ) begin
          if ({1'b0, CFG_SEL} >= (AW+1)'(NCFG)) begin
            err_d = 1'b1;
          end else begin
            cfg_d     = CFG_SEL;
            err_d     = 1'b0;
            retry_d   = '0;
            state_d   = ST_RSTP;
            rst_pll_d = 1'b1;
            idx_d     = '0;
            tmr_d     = '0;
          end
        end
      end
      ST_RSTP: begin
        if (tmr_q >= RST_LAST) begin
          state_d    = ST_FETCH;
          tbl_addr_d = {cfg_q, idx_q};
          ph_d       = 1'b0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      ST_FETCH: begin
        // First cycle presents the address, second lets the external ROM return data
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          state_d = ST_RD;
          den_d   = 1'b1;
          daddr_d = TBL_DATA[ADDR_LSB +: 5];
          tmr_d   = '0;
        end
      end
      ST_RD: begin
        if (DRDY) begin
          state_d = ST_WR;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          di_d    = rmw(DO, TBL_DATA[MASK_LSB +: 16], TBL_DATA[VAL_LSB +: 16]);
          tmr_d   = '0;
        end else if (tmr_q >= DRDY_LAST) begin
          err_d     = 1'b1;
          rst_pll_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      ST_WR: begin
        if (DRDY) begin
          if (idx_q >= IDX_LAST) begin
            state_d   = ST_REL;
            rst_pll_d = 1'b0;
          end else begin
            idx_d      = idx_q + IW'(1);
            tbl_addr_d = {cfg_q, idx_q + IW'(1)};
            ph_d       = 1'b0;
            state_d    = ST_FETCH;
          end
        end else if (tmr_q >= DRDY_LAST) begin
          err_d     = 1'b1;
          rst_pll_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      ST_REL: begin
        state_d = ST_WLOCK;
        tmr_d   = '0;
      end
      ST_WLOCK: begin
        if (lock_ok) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_q >= LOCK_LAST) begin
          rst_pll_d = 1'b1;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_RSTP;
            idx_d   = '0;
            tmr_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_inc;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_q    <= ST_BOOT;
      cfg_q      <= AW'(INIT_CFG);
      idx_q      <= '0;
      tmr_q      <= '0;
      retry_q    <= '0;
      ph_q       <= 1'b0;
      tbl_addr_q <= '0;
      daddr_q    <= '0;
      di_q       <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      rst_pll_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      retry_q    <= retry_d;
      ph_q       <= ph_d;
      tbl_addr_q <= tbl_addr_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      rst_pll_q  <= rst_pll_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign CFG_BUSY = busy_q;
  assign CFG_DONE = done_q;
  assign CFG_ERR  = err_q;
  assign TBL_ADDR = tbl_addr_q;
  assign DADDR    = daddr_q;
  assign DI       = di_q;
  assign DEN      = den_q;
  assign DWE      = dwe_q;
  assign RST_PLL  = rst_pll_q;
  assign LOCK_OK  = lock_ok;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// tb/tb_pll_reconf_seq.sv - self-checking bench for pll_reconf_seq
module tb_pll_reconf_seq;

  localparam int NCFG = 3, NREG = 3, INIT_CFG = 0, RST_CYC = 4;
  localparam int DRDY_TO = 16, LOCK_TO = 100, RETRY = 2;
  localparam int AW = 2, IW = 2;

  logic              CLK = 1'b0;
  logic              RSTX = 1'b0;
  logic [AW-1:0]     CFG_SEL = '0;
  logic              CFG_REQ = 1'b0;
  logic              CFG_BUSY, CFG_DONE, CFG_ERR;
  logic [AW+IW-1:0]  TBL_ADDR;
  logic [36:0]       TBL_DATA;
  logic [4:0]        DADDR;
  logic [15:0]       DI, DO;
  logic              DEN, DWE, DRDY;
  logic              LOCKED, RST_PLL, LOCK_OK;

  logic lock_en = 1'b1;
  logic drdy_block = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  pll_reconf_seq #(
    .NCFG(NCFG), .NREG(NREG), .INIT_CFG(INIT_CFG), .RST_CYC(RST_CYC),
    .DRDY_TO(DRDY_TO), .LOCK_TO(LOCK_TO), .RETRY(RETRY)
  ) dut (
    .CLK(CLK), .RSTX(RSTX), .CFG_SEL(CFG_SEL), .CFG_REQ(CFG_REQ),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR),
    .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA), .DADDR(DADDR), .DI(DI), .DO(DO),
    .DEN(DEN), .DWE(DWE), .DRDY(DRDY), .LOCKED(LOCKED), .RST_PLL(RST_PLL),
    .LOCK_OK(LOCK_OK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // PLL model: locks as soon as it leaves reset, if allowed to
  assign LOCKED = lock_en & ~RST_PLL;

  // Table ROM, one cycle read latency
  logic [36:0] rom [16];
  always @(posedge CLK) TBL_DATA <= rom[TBL_ADDR];

  // DRP slave with random DRDY latency and an access log
  logic [15:0] init_mem [32];
  logic [15:0] mem [32];
  logic        loaded = 1'b0;
  int          pend = 0;
  logic [4:0]  p_addr;
  logic        p_we;
  int          den_viol = 0;
  logic        obs_we [512];
  logic [4:0]  obs_addr [512];
  logic [15:0] obs_di [512];
  int          obs_n = 0;

  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
      loaded <= 1'b1;
    end
    DRDY <= 1'b0;
    DO   <= 16'($urandom);
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1 && !drdy_block) begin
        DRDY <= 1'b1;
        if (!p_we) DO <= mem[p_addr];
      end
    end
    if (DEN) begin
      if (pend > 0) den_viol <= den_viol + 1;
      pend   <= $urandom_range(1, 3);
      p_addr <= DADDR;
      p_we   <= DWE;
      if (DWE) mem[DADDR] <= DI;
      obs_we[obs_n]   <= DWE;
      obs_addr[obs_n] <= DADDR;
      obs_di[obs_n]   <= DWE ? DI : 16'h0;
      obs_n           <= obs_n + 1;
    end
  end

  // Event monitor sampled away from the active edge
  int rel_cyc = -1, drdy_cyc = -1, ta_n = 0;
  logic prev_rst = 1'b1;
  logic [AW+IW-1:0] ta_prev = '0;
  logic [AW+IW-1:0] ta_log [512];
  always @(negedge CLK) begin
    if (prev_rst && !RST_PLL) rel_cyc = cyc;
    prev_rst = RST_PLL;
    if (DRDY) drdy_cyc = cyc;
    if (TBL_ADDR != ta_prev) begin
      ta_log[ta_n] = TBL_ADDR;
      ta_n++;
    end
    ta_prev = TBL_ADDR;
  end

  // Reference model: expected DRP accesses from table contents and a memory image
  logic [15:0] refmem [32];
  logic        e_we [$];
  logic [4:0]  e_addr [$];
  logic [15:0] e_di [$];
  int          base = 0;

  task automatic model_pass(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      logic [36:0] e;
      logic [4:0]  a;
      e = rom[(c << IW) + i];
      a = e[36:32];
      e_we.push_back(1'b0); e_addr.push_back(a); e_di.push_back(16'h0);
      refmem[a] = (refmem[a] & e[31:16]) | e[15:0];
      e_we.push_back(1'b1); e_addr.push_back(a); e_di.push_back(refmem[a]);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_trace(input string tag);
    int n;
    n = e_we.size();
    chk({tag, "_len"}, 64'(obs_n - base), 64'(n));
    for (int i = 0; i < n && base + i < obs_n; i++)
      chk($sformatf("%s[%0d]", tag, i),
          {obs_we[base+i], obs_addr[base+i], obs_di[base+i]},
          {e_we[i], e_addr[i], e_di[i]});
    base = obs_n;
    e_we.delete(); e_addr.delete(); e_di.delete();
  endtask

  task automatic req(input logic [AW-1:0] sel);
    CFG_SEL = sel;
    CFG_REQ = 1'b1;
    @(negedge CLK);
    CFG_REQ = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output int nb);
    dcyc = -1;
    nb = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (CFG_DONE) begin
        dcyc = cyc;
        break;
      end
      if (!CFG_BUSY) nb++;
    end
  endtask

  task automatic wait_err(input int budget, output int ecyc);
    ecyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (CFG_ERR) begin
        ecyc = cyc;
        break;
      end
    end
  endtask

  initial begin
    int d, nb, ec, dc, tb0, sel;
    for (int i = 0; i < 16; i++) rom[i] = {5'($urandom), 16'($urandom), 16'($urandom)};
    rom[0] = {5'h08, 16'hF000, 16'h0041};
    for (int i = 0; i < 32; i++) init_mem[i] = 16'($urandom);
    init_mem[8] = 16'hABCD;
    for (int i = 0; i < 32; i++) refmem[i] = init_mem[i];

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_rst_pll", RST_PLL, 1);
    chk("rst_busy", CFG_BUSY, 0);
    chk("rst_done", CFG_DONE, 0);
    chk("rst_err", CFG_ERR, 0);
    chk("rst_den", DEN, 0);
    chk("rst_dwe", DWE, 0);
    chk("rst_tbl_addr", TBL_ADDR, 0);
    chk("rst_daddr", DADDR, 0);
    chk("rst_di", DI, 0);
    chk("rst_lock_ok", LOCK_OK, 0);

    // Boot sequence applies INIT_CFG
    RSTX = 1'b1;
    wait_done(400, d, nb);
    chk("boot_done_seen", d >= 0, 1);
    chk("boot_done_after_rel", 64'(d - rel_cyc), 11);
    chk("boot_rel_after_drdy", rel_cyc > drdy_cyc, 1);
    chk("boot_lock_ok", LOCK_OK, 1);
    chk("boot_first_wr", {obs_we[1], obs_addr[1], obs_di[1]}, {1'b1, 5'h08, 16'hA041});
    model_pass(INIT_CFG, NREG);
    cmp_trace("boot");
    @(negedge CLK);
    chk("boot_idle_busy", CFG_BUSY, 0);
    chk("boot_idle_rst_pll", RST_PLL, 0);
    chk("boot_idle_err", CFG_ERR, 0);

    // Select configuration 2, with a request pulsed while busy
    tb0 = ta_n;
    req(2);
    nb = 0;
    repeat (3) begin
      @(negedge CLK);
      if (!CFG_BUSY) nb++;
    end
    req(1);
    d = nb;
    wait_done(400, dc, nb);
    chk("sel2_done_seen", dc >= 0, 1);
    chk("sel2_busy_gaps", 64'(nb + d), 0);
    chk("sel2_tbl_walk_len", 64'(ta_n - tb0), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sel2_tbl_addr[%0d]", i), ta_log[tb0 + i], 64'((2 << IW) + i));
    model_pass(2, NREG);
    cmp_trace("sel2");

    // Random configurations
    for (int k = 0; k < 3; k++) begin
      sel = $urandom_range(0, NCFG - 1);
      @(negedge CLK);
      req(AW'(sel));
      wait_done(400, d, nb);
      chk($sformatf("rand%0d_done_after_rel", k), 64'(d - rel_cyc), 11);
      model_pass(sel, NREG);
      cmp_trace($sformatf("rand%0d", k));
    end

    // DRDY withheld: error exactly DRDY_TO cycles after DEN
    drdy_block = 1'b1;
    @(negedge CLK);
    req(1);
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      if (DEN) begin
        dc = cyc;
        break;
      end
      @(negedge CLK);
    end
    wait_err(200, ec);
    chk("drdy_to_latency", 64'(ec - dc), DRDY_TO);
    chk("drdy_to_rst_pll", RST_PLL, 1);
    chk("drdy_to_busy", CFG_BUSY, 0);
    e_we.push_back(1'b0); e_addr.push_back(rom[1 << IW][36:32]); e_di.push_back(16'h0);
    cmp_trace("drdy_to");
    drdy_block = 1'b0;
    repeat (5) @(negedge CLK);

    // Lock never arrives: initial pass plus RETRY retries, then error
    lock_en = 1'b0;
    req(0);
    chk("retry_err_cleared", CFG_ERR, 0);
    wait_err(3000, ec);
    chk("retry_err_seen", ec >= 0, 1);
    chk("retry_busy", CFG_BUSY, 0);
    chk("retry_rst_pll", RST_PLL, 1);
    for (int p = 0; p <= RETRY; p++) model_pass(0, NREG);
    cmp_trace("retry");

    // Next request clears the error and succeeds
    lock_en = 1'b1;
    @(negedge CLK);
    req(0);
    chk("recover_err_cleared", CFG_ERR, 0);
    wait_done(400, d, nb);
    chk("recover_done_seen", d >= 0, 1);
    model_pass(0, NREG);
    cmp_trace("recover");

    // Out-of-range selection is rejected without touching the PLL
    @(negedge CLK);
    req(3);
    chk("badsel_err", CFG_ERR, 1);
    chk("badsel_busy", CFG_BUSY, 0);
    chk("badsel_rst_pll", RST_PLL, 0);
    repeat (10) @(negedge CLK);
    chk("badsel_no_drp", 64'(obs_n - base), 0);
    chk("badsel_still_idle", CFG_BUSY, 0);
    chk("badsel_lock_ok", LOCK_OK, 1);

    // Reset during a write, then boot reruns INIT_CFG
    req(1);
    chk("abort_err_cleared", CFG_ERR, 0);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      if (DEN && DWE) begin
        dc = cyc;
        break;
      end
      @(negedge CLK);
    end
    chk("abort_wr_seen", dc >= 0, 1);
    RSTX = 1'b0;
    @(negedge CLK);
    chk("abort_den", DEN, 0);
    chk("abort_dwe", DWE, 0);
    chk("abort_rst_pll", RST_PLL, 1);
    chk("abort_busy", CFG_BUSY, 0);
    model_pass(1, 1);
    cmp_trace("abort");
    RSTX = 1'b1;
    wait_done(400, d, nb);
    chk("reboot_done_after_rel", 64'(d - rel_cyc), 11);
    model_pass(INIT_CFG, NREG);
    cmp_trace("reboot");

    chk("den_protocol", den_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
